// File: rtl/counter_rr_scheduler.sv
// Round-robin scheduler that lends one shared up-counter to NREQ requesters
// for timed windows, holding the counter cleared whenever no window is running.
module counter_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int BW   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*BW-1:0]   len_i,
    input  logic [BW-1:0]        cnt_val_i,
    output logic                 cnt_clr_o,
    output logic [NREQ-1:0]      grant_o,
    output logic [NREQ-1:0]      done_o,
    output logic                 busy_o
);

    localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_win;
    logic [BW-1:0]   r_len;
    logic [NREQ-1:0] r_grant;
    logic [NREQ-1:0] r_done;

    logic [PW-1:0]   w_win;
    logic [BW-1:0]   w_lenSel;
    logic [BW-1:0]   w_lenEff;
    logic            w_abandon;
    logic            w_last;

    // Scan from the farthest candidate back to ptr+1 so the closest request wins.
    always_comb begin
        w_win = r_ptr;
        for (int k = NREQ; k >= 1; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if ((i == ((int'(r_ptr) + k) % NREQ)) && req_i[i]) begin
                    w_win = PW'(i);
                end
            end
        end
    end

    always_comb begin
        w_lenSel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == PW'(i)) begin
                w_lenSel = len_i[i*BW +: BW];
            end
        end
    end

    assign w_lenEff  = (w_lenSel == '0) ? BW'(1) : w_lenSel;
    assign w_abandon = ~|(req_i & r_grant);
    assign w_last    = (cnt_val_i == (r_len - BW'(1)));

    // Abandon is tested first so it wins over a coincident completion.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_ptr   <= PW'(NREQ - 1);
            r_win   <= '0;
            r_len   <= '0;
            r_grant <= '0;
            r_done  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= '0;
                    if (|req_i) begin
                        r_win   <= w_win;
                        r_len   <= w_lenEff;
                        r_grant <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_abandon) begin
                        r_grant <= '0;
                        r_ptr   <= r_win;
                        r_state <= S_IDLE;
                    end else if (w_last) begin
                        r_done  <= r_grant;
                        r_grant <= '0;
                        r_ptr   <= r_win;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_grant <= '0;
                    r_done  <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cnt_clr_o = (r_state != S_RUN);
    assign grant_o   = r_grant;
    assign done_o    = r_done;
    assign busy_o    = (r_state != S_IDLE);

endmodule

// File: tb/tb_counter_rr_scheduler.sv
// Scoreboard bench: stimulus pushes expected windows, a negedge monitor
// reconstructs each grant window from the DUT and pops/compares it.
module tb_counter_rr_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  reqIn;
    logic [31:0] lenIn;
    logic [7:0]  cntVal;
    logic        cntClr;
    logic [3:0]  grantOut;
    logic [3:0]  doneOut;
    logic        busyOut;

    int totalCount = 0;
    int badCount   = 0;

    typedef struct {
        logic [3:0] grant;
        int         len;
        int         done;
        int         firstCnt;
        int         lastCnt;
        int         gap;
    } winT;

    winT expQ[$];

    counter_rr_scheduler #(.NREQ(4), .BW(8)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (reqIn),
        .len_i     (lenIn),
        .cnt_val_i (cntVal),
        .cnt_clr_o (cntClr),
        .grant_o   (grantOut),
        .done_o    (doneOut),
        .busy_o    (busyOut)
    );

    // The shared counter the scheduler lends out.
    always_ff @(posedge clk) begin
        if (cntClr) cntVal <= '0;
        else        cntVal <= cntVal + 8'd1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        totalCount++;
        if (act != exp) begin
            badCount++;
            $display("[TB] FAIL %s: got=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic [7:0] l0, input logic [7:0] l1,
                                 input logic [7:0] l2, input logic [7:0] l3);
        reqIn = req;
        lenIn = {l3, l2, l1, l0};
    endtask

    task automatic pushExp(input logic [3:0] grant, input int len, input int done, input int gap);
        winT e;
        e.grant    = grant;
        e.len      = len;
        e.done     = done;
        e.firstCnt = 0;
        e.lastCnt  = len - 1;
        e.gap      = gap;
        expQ.push_back(e);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitDone(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (doneOut != 4'b0) return;
        end
        checkOutput("doneTimeout", 0, 1);
    endtask

    task automatic waitGrantOn(input int idx, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (grantOut[idx]) return;
        end
        checkOutput("grantTimeout", 0, 1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_grant"}, int'(grantOut), 0);
        checkOutput({tag, "_done"}, int'(doneOut), 0);
        checkOutput({tag, "_busy"}, int'(busyOut), 0);
        checkOutput({tag, "_clr"}, int'(cntClr), 1);
    endtask

    logic [3:0] prevGrant = 4'b0;
    int         winLen    = 0;
    int         firstSeen = 0;
    int         lastSeen  = 0;
    int         gapSeen   = 0;
    int         zeroRun   = 0;

    // Monitor: per-cycle invariants plus window reconstruction on grant edges.
    always @(negedge clk) begin
        checkOutput("grantDoneExcl", int'((grantOut != 0) && (doneOut != 0)), 0);
        checkOutput("grantOneHot", int'($onehot0(grantOut)), 1);
        checkOutput("doneOneHot", int'($onehot0(doneOut)), 1);
        checkOutput("busyDecode", int'(busyOut), int'((grantOut != 0) || (doneOut != 0)));
        checkOutput("clrDecode", int'(cntClr), int'(grantOut == 0));
        if (grantOut != 4'b0) begin
            if (prevGrant == 4'b0) begin
                winLen    = 0;
                firstSeen = int'(cntVal);
                gapSeen   = zeroRun;
            end
            winLen++;
            lastSeen = int'(cntVal);
        end else begin
            if (prevGrant != 4'b0) begin
                if (expQ.size() == 0) begin
                    totalCount++;
                    badCount++;
                    $display("[TB] FAIL unexpectedWindow: got grant=%b expected none", prevGrant);
                end else begin
                    winT e;
                    e = expQ.pop_front();
                    checkOutput("winGrant", int'(prevGrant), int'(e.grant));
                    checkOutput("winLen", winLen, e.len);
                    checkOutput("winDone", int'(doneOut == prevGrant), e.done);
                    checkOutput("winFirstCnt", firstSeen, e.firstCnt);
                    checkOutput("winLastCnt", lastSeen, e.lastCnt);
                    if (e.gap >= 0) checkOutput("winGap", gapSeen, e.gap);
                end
                zeroRun = 0;
            end
            zeroRun++;
        end
        prevGrant = grantOut;
    end

    initial begin
        rst = 1'b1;
        applyStimulus(4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
        waitCycles(2);
        checkResetOutputs("reset");
        rst = 1'b0;
        waitCycles(2);

        applyStimulus(4'b0001, 8'd3, 8'd0, 8'd0, 8'd0);
        pushExp(4'b0001, 3, 1, -1);
        waitDone(20);
        reqIn = 4'b0000;
        waitCycles(3);

        applyStimulus(4'b0001, 8'd0, 8'd0, 8'd0, 8'd0);
        pushExp(4'b0001, 1, 1, -1);
        waitDone(20);
        reqIn = 4'b0000;
        waitCycles(3);

        applyStimulus(4'b0001, 8'd255, 8'd0, 8'd0, 8'd0);
        pushExp(4'b0001, 255, 1, -1);
        waitDone(400);
        reqIn = 4'b0000;
        waitCycles(3);

        // Contention from a fresh reset: pointer starts so requester 0 leads.
        rst = 1'b1;
        waitCycles(2);
        rst = 1'b0;
        applyStimulus(4'b1111, 8'd2, 8'd2, 8'd2, 8'd2);
        pushExp(4'b0001, 2, 1, -1);
        pushExp(4'b0010, 2, 1, 2);
        pushExp(4'b0100, 2, 1, 2);
        pushExp(4'b1000, 2, 1, 2);
        pushExp(4'b0001, 2, 1, 2);
        repeat (5) waitDone(20);
        reqIn = 4'b0000;
        waitCycles(3);

        applyStimulus(4'b0100, 8'd2, 8'd2, 8'd2, 8'd2);
        pushExp(4'b0100, 2, 1, -1);
        waitDone(20);
        reqIn = 4'b0000;
        waitCycles(2);
        applyStimulus(4'b0101, 8'd2, 8'd2, 8'd2, 8'd2);
        pushExp(4'b0001, 2, 1, -1);
        pushExp(4'b0100, 2, 1, 2);
        waitDone(20);
        waitDone(20);
        reqIn = 4'b0000;
        waitCycles(3);

        // Abandon in the 4th window cycle; pointer then sits at requester 1.
        applyStimulus(4'b0010, 8'd2, 8'd10, 8'd2, 8'd2);
        pushExp(4'b0010, 4, 0, -1);
        waitGrantOn(1, 10);
        waitCycles(3);
        reqIn = 4'b0000;
        waitCycles(3);
        applyStimulus(4'b1111, 8'd2, 8'd2, 8'd2, 8'd2);
        pushExp(4'b0100, 2, 1, -1);
        waitDone(20);
        reqIn = 4'b0000;
        waitCycles(3);

        applyStimulus(4'b0010, 8'd2, 8'd10, 8'd2, 8'd2);
        pushExp(4'b0010, 10, 0, -1);
        waitGrantOn(1, 10);
        waitCycles(9);
        reqIn = 4'b0000;
        waitCycles(3);

        // Asynchronous reset landing after the negedge of the 3rd window cycle.
        applyStimulus(4'b0001, 8'd6, 8'd2, 8'd2, 8'd2);
        pushExp(4'b0001, 3, 0, -1);
        waitGrantOn(0, 10);
        repeat (2) @(posedge clk);
        #7;
        rst   = 1'b1;
        reqIn = 4'b0000;
        #1;
        checkResetOutputs("asyncReset");
        waitCycles(2);
        rst = 1'b0;
        applyStimulus(4'b1111, 8'd2, 8'd2, 8'd2, 8'd2);
        pushExp(4'b0001, 2, 1, -1);
        waitDone(20);
        reqIn = 4'b0000;
        waitCycles(4);

        checkOutput("queueEmpty", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/counter_rr_scheduler.md
Name: counter_rr_scheduler

Overview:
- Shares one free-running up-counter (sync active-high clear, +1 per clock, width BW) between NREQ requesters.
- Each requester asks for an exclusive timed window of L clock cycles.
- The block arbitrates round-robin, holds the counter cleared while idle, releases it for the granted window, and ends the window when the count reaches L-1.
- Sits directly beside the counter instance: cnt_clr_o drives the counter's clear, and the counter value feeds back into cnt_val_i.

Parameters:
- NREQ, 4, number of requesters (2..8).
- BW, 8, counter and window-length width; must equal the width of the counter instance.

Ports:
- clk_i  input  1  system clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- req_i  input  NREQ  request per requester; level, held until done or abandoned.
- len_i  input  NREQ*BW  packed window lengths; requester i uses bits [i*BW +: BW].
- cnt_val_i  input  BW  current value from the shared counter.
- cnt_clr_o  output  1  clear to the shared counter (drives its reset input).
- grant_o  output  NREQ  one-hot grant; all-zero when no window is active.
- done_o  output  NREQ  one-cycle completion pulse to the granted requester.
- busy_o  output  1  high while state is not IDLE.

Behaviour:
- Reset (async, any time, including mid-window):
  - state=IDLE, grant_o=0, done_o=0, busy_o=0, cnt_clr_o=1.
  - Round-robin pointer ptr=NREQ-1, so requester 0 has first priority.
  - Latched length len_q=0.
- States: IDLE, RUN, DONE. All outputs are decoded from registered state/grant only; no combinational path from req_i to any output.
- cnt_clr_o=1 in IDLE and DONE, 0 in RUN. The counter is therefore 0 in the first RUN cycle.
- IDLE:
  - If req_i != 0 at a rising edge, select winner w = first set bit searching ptr+1, ptr+2, ... with wrap modulo NREQ.
  - Latch len_q = max(len_i[w], 1), so a length of 0 is treated as 1.
  - Set grant_o = 1<<w and go to RUN.
  - If req_i == 0, stay in IDLE.
- RUN:
  - grant_o is held constant; len_i changes are ignored after latching.
  - If cnt_val_i == len_q-1 at a rising edge, go to DONE. grant_o is therefore high for exactly len_q cycles.
  - Abandon: if req_i[w]==0 at a rising edge before completion, go straight to IDLE. No done pulse; grant_o=0; ptr=w.
  - If abandon and completion coincide on the same edge, abandon wins.
- DONE (exactly one cycle):
  - done_o = 1<<w, grant_o=0, ptr=w, cnt_clr_o=1; then go to IDLE unconditionally.
  - The requester should drop req_i on seeing done_o. A req_i still high in the following IDLE cycle is treated as a new request.
- Back-to-back throughput: DONE -> IDLE -> RUN, so there are exactly 2 cycles with grant_o=0 between consecutive windows.
- Arithmetic:
  - len_q is at most 2^BW-1, so cnt_val_i reaches at most 2^BW-2 and never wraps.
  - The compare is an unsigned BW-bit equality.
- Request changes from non-winners during RUN have no effect until the next IDLE arbitration.
- A requester whose req_i drops while it is not granted loses nothing; no pending state is stored.
- Invariants:
  - grant_o and done_o are never non-zero in the same cycle.
  - Each is at most one-hot.
  - busy_o == (grant_o != 0) || (done_o != 0).

Test Plan (bench instantiates the real BW-bit counter, cnt_clr_o -> counter reset):
- Single request: req_i=0001, len0=3 -> grant_o=0001 for exactly 3 cycles, cnt_val_i seen as 0,1,2; done_o=0001 for 1 cycle; busy_o drops one cycle later.
- Zero and maximum length: len0=0 -> 1-cycle grant then done. With BW=8 and len0=255 -> 255-cycle grant, final cnt_val_i=254, no wrap.
- Contention: req_i=1111 held, all lengths 2, after reset:
  - Grant order is 0,1,2,3,0.
  - Each window is 2 cycles with a 2-cycle gap.
  - done_o pulses follow the same order.
- Round-robin fairness: after requester 2 completes, assert req_i=0101 -> requester 0 is granted before 2 (ptr=2 search order 3,0,1,2).
- Abandon: len1=10, drop req_i[1] in the 4th RUN cycle -> next cycle grant_o=0, no done_o, state IDLE, ptr=1.
  - Same test with the drop on the last RUN cycle -> abandon wins, no done_o.
- Async reset mid-window: assert rst_i between clock edges during RUN (len=6, cycle 3) -> grant_o, done_o and busy_o go to 0 immediately and cnt_clr_o=1.
  - After release, with req_i=1111 -> requester 0 is granted first.
